// File: rtl/adder_carry_select_pipe.sv
// rtl/adder_carry_select_pipe.sv - two-stage pipelined carry-select adder/subtractor with val/rdy handshakes
module adder_carry_select_pipe #(
    parameter int p_nbits = 32,
    parameter int p_blk   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic               cin,
    input  logic               sub,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] sum,
    output logic               cout,
    output logic               ovf
);

    localparam int NB = p_nbits / p_blk;
    localparam int HB = NB / 2;
    localparam int HW = HB * p_blk;
    localparam logic [p_blk:0] ONE = (p_blk + 1)'(1);

    if (p_nbits % (2 * p_blk) != 0) begin : g_bad_width
        $error("p_nbits must be a multiple of 2*p_blk");
    end

    // operand preparation and stage-1 block results
    logic [p_nbits-1:0] b_w;
    logic               c0_w;
    logic [p_blk:0]     t0_w, t1_w;
    logic               c1_w;
    logic [HW-1:0]      lo_sum_w, hi_sum0_w, hi_sum1_w;
    logic [HB-1:0]      hi_co0_w, hi_co1_w;
    logic               mid_c_w, cmsb0_w, cmsb1_w;

    // stage-1 registers
    logic               s1_val_q, s1_val_d;
    logic [HW-1:0]      s1_lo_sum_q, s1_lo_sum_d;
    logic [HW-1:0]      s1_hi_sum0_q, s1_hi_sum0_d, s1_hi_sum1_q, s1_hi_sum1_d;
    logic [HB-1:0]      s1_hi_co0_q, s1_hi_co0_d, s1_hi_co1_q, s1_hi_co1_d;
    logic               s1_mid_c_q, s1_mid_c_d;
    logic               s1_cmsb0_q, s1_cmsb0_d, s1_cmsb1_q, s1_cmsb1_d;

    // stage-2 resolution and output registers
    logic               c2_w, ctop_w;
    logic [HW-1:0]      hi_sum_w;
    logic               cout_w, ovf_w;
    logic               out_val_q, out_val_d;
    logic [p_nbits-1:0] sum_q, sum_d;
    logic               cout_q, cout_d, ovf_q, ovf_d;

    logic               s2_adv, accept;

    // both carry variants per block; lower half resolved from c0, upper half kept raw
    always_comb begin
        b_w       = sub ? ~in1 : in1;
        c0_w      = sub ? 1'b1 : cin;
        c1_w      = c0_w;
        t0_w      = '0;
        t1_w      = '0;
        lo_sum_w  = '0;
        hi_sum0_w = '0;
        hi_sum1_w = '0;
        hi_co0_w  = '0;
        hi_co1_w  = '0;
        for (int i = 0; i < NB; i++) begin
            t0_w = {1'b0, in0[i*p_blk +: p_blk]} + {1'b0, b_w[i*p_blk +: p_blk]};
            t1_w = {1'b0, in0[i*p_blk +: p_blk]} + {1'b0, b_w[i*p_blk +: p_blk]} + ONE;
            if (i < HB) begin
                lo_sum_w[i*p_blk +: p_blk] = c1_w ? t1_w[p_blk-1:0] : t0_w[p_blk-1:0];
                c1_w = c1_w ? t1_w[p_blk] : t0_w[p_blk];
            end else begin
                hi_sum0_w[(i-HB)*p_blk +: p_blk] = t0_w[p_blk-1:0];
                hi_sum1_w[(i-HB)*p_blk +: p_blk] = t1_w[p_blk-1:0];
                hi_co0_w[i-HB] = t0_w[p_blk];
                hi_co1_w[i-HB] = t1_w[p_blk];
            end
        end
        mid_c_w = c1_w;
        // carry into the MSB recovered from the MSB sum bit of each top-block variant
        cmsb0_w = hi_sum0_w[HW-1] ^ in0[p_nbits-1] ^ b_w[p_nbits-1];
        cmsb1_w = hi_sum1_w[HW-1] ^ in0[p_nbits-1] ^ b_w[p_nbits-1];
    end

    // stage 2: resolve the upper select chain from the registered mid carry
    always_comb begin
        c2_w     = s1_mid_c_q;
        ctop_w   = s1_mid_c_q;
        hi_sum_w = '0;
        for (int j = 0; j < HB; j++) begin
            hi_sum_w[j*p_blk +: p_blk] = c2_w ? s1_hi_sum1_q[j*p_blk +: p_blk]
                                              : s1_hi_sum0_q[j*p_blk +: p_blk];
            ctop_w = c2_w;
            c2_w   = c2_w ? s1_hi_co1_q[j] : s1_hi_co0_q[j];
        end
        cout_w = c2_w;
        ovf_w  = (ctop_w ? s1_cmsb1_q : s1_cmsb0_q) ^ c2_w;
    end

    // handshake and next-state selection for both stages
    always_comb begin
        s2_adv       = !out_val_q || out_rdy;
        in_rdy       = !s1_val_q || s2_adv;
        accept       = in_val && in_rdy;

        s1_val_d     = in_rdy ? in_val : s1_val_q;
        s1_lo_sum_d  = accept ? lo_sum_w  : s1_lo_sum_q;
        s1_hi_sum0_d = accept ? hi_sum0_w : s1_hi_sum0_q;
        s1_hi_sum1_d = accept ? hi_sum1_w : s1_hi_sum1_q;
        s1_hi_co0_d  = accept ? hi_co0_w  : s1_hi_co0_q;
        s1_hi_co1_d  = accept ? hi_co1_w  : s1_hi_co1_q;
        s1_mid_c_d   = accept ? mid_c_w   : s1_mid_c_q;
        s1_cmsb0_d   = accept ? cmsb0_w   : s1_cmsb0_q;
        s1_cmsb1_d   = accept ? cmsb1_w   : s1_cmsb1_q;

        out_val_d    = s2_adv ? s1_val_q : out_val_q;
        sum_d        = sum_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;
        if (s2_adv && s1_val_q) begin
            sum_d  = {hi_sum_w, s1_lo_sum_q};
            cout_d = cout_w;
            ovf_d  = ovf_w;
        end
    end

    // pipeline registers; reset empties both stages and clears the outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_val_q     <= 1'b0;
            s1_lo_sum_q  <= '0;
            s1_hi_sum0_q <= '0;
            s1_hi_sum1_q <= '0;
            s1_hi_co0_q  <= '0;
            s1_hi_co1_q  <= '0;
            s1_mid_c_q   <= 1'b0;
            s1_cmsb0_q   <= 1'b0;
            s1_cmsb1_q   <= 1'b0;
            out_val_q    <= 1'b0;
            sum_q        <= '0;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            s1_val_q     <= s1_val_d;
            s1_lo_sum_q  <= s1_lo_sum_d;
            s1_hi_sum0_q <= s1_hi_sum0_d;
            s1_hi_sum1_q <= s1_hi_sum1_d;
            s1_hi_co0_q  <= s1_hi_co0_d;
            s1_hi_co1_q  <= s1_hi_co1_d;
            s1_mid_c_q   <= s1_mid_c_d;
            s1_cmsb0_q   <= s1_cmsb0_d;
            s1_cmsb1_q   <= s1_cmsb1_d;
            out_val_q    <= out_val_d;
            sum_q        <= sum_d;
            cout_q       <= cout_d;
            ovf_q        <= ovf_d;
        end
    end

    assign out_val = out_val_q;
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;

endmodule
